// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
// State encodings and reset-time constants.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_FULL = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// RV32 fetch stage: PC, single outstanding imem request,
// one-entry output buffer, branch redirect handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
);

  fetch_state_e state, state_d;
  logic [31:0]  pc, pc_d;
  logic [31:0]  req_addr, req_addr_d;
  logic         kill, kill_d;
  logic [31:0]  buf_instr, buf_instr_d;
  logic [31:0]  buf_pc, buf_pc_d;

  logic         redirect;
  logic [31:0]  redir_addr;
  logic [31:0]  pc_inc;

  assign redirect   = br_valid && (br_target != 32'd0);
  assign redir_addr = {br_target[31:2], 2'b00};
  assign pc_inc     = req_addr + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH_BOOT;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      kill      <= 1'b0;
      buf_instr <= NOP_INSTR;
      buf_pc    <= RESET_PC;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      req_addr  <= req_addr_d;
      kill      <= kill_d;
      buf_instr <= buf_instr_d;
      buf_pc    <= buf_pc_d;
    end
  end

  always_comb begin
    state_d     = state;
    pc_d        = pc;
    req_addr_d  = req_addr;
    kill_d      = kill;
    buf_instr_d = buf_instr;
    buf_pc_d    = buf_pc;
    imem_req    = 1'b0;
    unique case (state)
      FETCH_BOOT: begin
        state_d    = FETCH_REQ;
        pc_d       = RESET_PC;
        req_addr_d = RESET_PC;
      end
      FETCH_REQ: begin
        imem_req = 1'b1;
        // the stale request still completes; kill drops its data
        if (redirect) begin
          pc_d   = redir_addr;
          kill_d = 1'b1;
        end
        if (imem_gnt) state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          if (redirect) begin
            kill_d     = 1'b0;
            pc_d       = redir_addr;
            req_addr_d = redir_addr;
            state_d    = FETCH_REQ;
          end else if (kill) begin
            kill_d     = 1'b0;
            req_addr_d = pc;
            state_d    = FETCH_REQ;
          end else begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = req_addr;
            pc_d        = pc_inc;
            state_d     = FETCH_FULL;
          end
        end else if (redirect) begin
          pc_d   = redir_addr;
          kill_d = 1'b1;
        end
      end
      FETCH_FULL: begin
        if (redirect) begin
          pc_d       = redir_addr;
          req_addr_d = redir_addr;
          state_d    = FETCH_REQ;
        end else if (id_ready) begin
          req_addr_d = pc;
          state_d    = FETCH_REQ;
        end
      end
      default: state_d = FETCH_BOOT;
    endcase
  end

  // branch is older than the buffered word, so squash it now
  assign if_valid  = (state == FETCH_FULL) && !redirect;
  assign if_instr  = buf_instr;
  assign if_pc     = buf_pc;
  assign imem_addr = req_addr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Each task drives one scenario and checks inline.
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst;
  logic        br_valid;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  int ncmp;
  int nbad;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .id_ready    (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // From a REQ cycle: grant, respond next cycle, end in FULL.
  task automatic go_full(input logic [31:0] a);
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = a ^ K;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ncmp++;
      if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
        nbad++;
        $display("FAIL reset_ctl req=%b valid=%b need 0/0",
                 imem_req, if_valid);
      end
      ncmp++;
      if (if_instr !== 32'h13 || if_pc !== 32'h0) begin
        nbad++;
        $display("FAIL reset_buf instr=%h pc=%h need 13/0",
                 if_instr, if_pc);
      end
    end
    rst = 1'b0;
    #1;
    ncmp++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      nbad++;
      $display("FAIL boot req=%b addr=%h need 0/0",
               imem_req, imem_addr);
    end
    tick();
    ncmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      nbad++;
      $display("FAIL first_req req=%b addr=%h need 1/0",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i * 4);
      ncmp++;
      if (imem_req !== 1'b1 || imem_addr !== a) begin
        nbad++;
        $display("FAIL seq_req req=%b addr=%h need 1/%h",
                 imem_req, imem_addr, a);
      end
      go_full(a);
      ncmp++;
      if (if_valid !== 1'b1 || if_pc !== a || if_instr !== (a ^ K)) begin
        nbad++;
        $display("FAIL seq_pkt v=%b pc=%h in=%h need 1/%h/%h",
                 if_valid, if_pc, if_instr, a, a ^ K);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    go_full(32'h10);
    for (int i = 0; i < 5; i++) begin
      ncmp++;
      if (if_valid !== 1'b1 || if_pc !== 32'h10 ||
          if_instr !== (32'h10 ^ K) || imem_req !== 1'b0) begin
        nbad++;
        $display("FAIL stall v=%b pc=%h in=%h req=%b need 1/10/%h/0",
                 if_valid, if_pc, if_instr, imem_req, 32'h10 ^ K);
      end
      tick();
    end
    id_ready = 1'b1;
    tick();
    ncmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h14 || if_valid !== 1'b0) begin
      nbad++;
      $display("FAIL stall_next req=%b addr=%h v=%b need 1/14/0",
               imem_req, imem_addr, if_valid);
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    id_ready = 1'b1;
    go_full(32'h0);
    tick();
    go_full(32'h4);
    tick();
    go_full(32'h8);
    id_ready  = 1'b0;
    br_valid  = 1'b1;
    br_target = 32'h0;
    #1;
    ncmp++;
    if (if_valid !== 1'b1 || if_pc !== 32'h8) begin
      nbad++;
      $display("FAIL br_zero v=%b pc=%h need 1/8", if_valid, if_pc);
    end
    tick();
    ncmp++;
    if (if_valid !== 1'b1 || imem_req !== 1'b0) begin
      nbad++;
      $display("FAIL br_zero_hold v=%b req=%b need 1/0",
               if_valid, imem_req);
    end
    br_target = 32'h100;
    #1;
    ncmp++;
    if (if_valid !== 1'b0) begin
      nbad++;
      $display("FAIL br_full_kill v=%b need 0", if_valid);
    end
    tick();
    br_valid  = 1'b0;
    br_target = 32'h0;
    ncmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      nbad++;
      $display("FAIL br_full_req req=%b addr=%h need 1/100",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      go_full(32'(i * 4));
      tick();
    end
    imem_gnt = 1'b1;
    tick();
    imem_gnt  = 1'b0;
    br_valid  = 1'b1;
    br_target = 32'h203;
    tick();
    br_valid    = 1'b0;
    br_target   = 32'h0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    ncmp++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
      nbad++;
      $display("FAIL wait_drain v=%b req=%b need 0/0",
               if_valid, imem_req);
    end
    tick();
    imem_rvalid = 1'b0;
    ncmp++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      nbad++;
      $display("FAIL wait_req v=%b req=%b addr=%h need 0/1/200",
               if_valid, imem_req, imem_addr);
    end
    go_full(32'h200);
    ncmp++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200 ||
        if_instr !== (32'h200 ^ K)) begin
      nbad++;
      $display("FAIL wait_pkt v=%b pc=%h in=%h need 1/200/%h",
               if_valid, if_pc, if_instr, 32'h200 ^ K);
    end
  endtask

  task automatic test_redirect_rvalid();
    tick();
    ncmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin
      nbad++;
      $display("FAIL co_pre req=%b addr=%h need 1/204",
               imem_req, imem_addr);
    end
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    br_valid    = 1'b1;
    br_target   = 32'h300;
    tick();
    imem_rvalid = 1'b0;
    br_valid    = 1'b0;
    br_target   = 32'h0;
    ncmp++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      nbad++;
      $display("FAIL co_req v=%b req=%b addr=%h need 0/1/300",
               if_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    imem_gnt  = 1'b1;
    br_valid  = 1'b1;
    br_target = 32'hFFFF_FFFC;
    tick();
    imem_gnt    = 1'b0;
    br_valid    = 1'b0;
    br_target   = 32'h0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0BAD_0BAD;
    tick();
    imem_rvalid = 1'b0;
    ncmp++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 ||
        imem_addr !== 32'hFFFF_FFFC) begin
      nbad++;
      $display("FAIL req_redir v=%b req=%b addr=%h need 0/1/fffffffc",
               if_valid, imem_req, imem_addr);
    end
    id_ready = 1'b1;
    go_full(32'hFFFF_FFFC);
    ncmp++;
    if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC ||
        if_instr !== (32'hFFFF_FFFC ^ K)) begin
      nbad++;
      $display("FAIL wrap_pkt v=%b pc=%h in=%h need 1/fffffffc/%h",
               if_valid, if_pc, if_instr, 32'hFFFF_FFFC ^ K);
    end
    tick();
    ncmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      nbad++;
      $display("FAIL wrap_req req=%b addr=%h need 1/0",
               imem_req, imem_addr);
    end
  endtask

  initial begin
    ncmp        = 0;
    nbad        = 0;
    rst         = 1'b1;
    br_valid    = 1'b0;
    br_target   = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    id_ready    = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_full();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
